id_operand_pipe: RTL

- Parametrised successor to the ID-stage operand generator: decodes operand sources, resolves register operands through N bypass sources, and registers operand_1, operand_2 and store_data into a valid/ready ID→EX pipeline slot.
- Detects load-use hazards (bypass match on a pending result), stalls the slot, and counts stall cycles.
- Sits between the register-file read and the EX stage.

---
 rtl/id_operand_pipe_pkg.sv | 48 ++++
 rtl/id_operand_pipe_fwd_resolve.sv | 33 +++
 rtl/id_operand_pipe.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/id_operand_pipe_pkg.sv
// Opcode/funct definitions and operand-select encodings shared by the ID operand pipe.
package id_operand_pipe_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_BLTZ    = 6'h01;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0a;
  localparam logic [5:0] OP_SLTIU   = 6'h0b;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_XORI    = 6'h0e;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] FN_JALR    = 6'h09;

  typedef enum logic [1:0] {
    OPD1_REG,
    OPD1_LINK,
    OPD1_ZERO
  } opd1_sel_e;

  typedef enum logic [2:0] {
    OPD2_REG,
    OPD2_SEXT,
    OPD2_ZEXT,
    OPD2_HI,
    OPD2_ZERO
  } opd2_sel_e;

  function automatic logic is_store_op(input logic [5:0] opc);
    return (opc == OP_SB) || (opc == OP_SH) || (opc == OP_SW);
  endfunction

  function automatic logic is_load_op(input logic [5:0] opc);
    return (opc == OP_LB) || (opc == OP_LH) || (opc == OP_LW) ||
           (opc == OP_LBU) || (opc == OP_LHU);
  endfunction

endpackage

// File: rtl/id_operand_pipe_fwd_resolve.sv
// Priority bypass match for one source register: youngest (index 0) matching source wins.
module id_operand_pipe_fwd_resolve
  import id_operand_pipe_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int FWD_SRC = 2
) (
  input  logic [REG_W-1:0]          reg_addr,
  input  logic [DATA_W-1:0]         reg_data,
  input  logic [FWD_SRC-1:0]        fwd_valid,
  input  logic [FWD_SRC-1:0]        fwd_pending,
  input  logic [FWD_SRC*REG_W-1:0]  fwd_addr,
  input  logic [FWD_SRC*DATA_W-1:0] fwd_data,
  output logic [DATA_W-1:0]         data,
  output logic                      pending
);

  // Scan oldest to youngest so the lowest matching index overwrites last; r0 is never bypassed.
  always_comb begin
    data    = reg_data;
    pending = 1'b0;
    if (reg_addr != '0) begin
      for (int i = FWD_SRC - 1; i >= 0; i--) begin
        if (fwd_valid[i] && (fwd_addr[i*REG_W +: REG_W] == reg_addr)) begin
          data    = fwd_data[i*DATA_W +: DATA_W];
          pending = fwd_pending[i];
        end
      end
    end
  end

endmodule

// File: rtl/id_operand_pipe.sv
// ID-stage operand generator: decodes operand sources, resolves bypasses, detects
// load-use hazards and registers the operands into a valid/ready slot toward EX.
module id_operand_pipe
  import id_operand_pipe_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int REG_W   = 5,
  parameter int FWD_SRC = 2,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [5:0]                op,
  input  logic [5:0]                funct,
  input  logic [15:0]               imm,
  input  logic [REG_W-1:0]          rs_addr,
  input  logic [REG_W-1:0]          rt_addr,
  input  logic [DATA_W-1:0]         reg_data_1,
  input  logic [DATA_W-1:0]         reg_data_2,
  input  logic [FWD_SRC-1:0]        fwd_valid,
  input  logic [FWD_SRC-1:0]        fwd_pending,
  input  logic [FWD_SRC*REG_W-1:0]  fwd_addr,
  input  logic [FWD_SRC*DATA_W-1:0] fwd_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         operand_1,
  output logic [DATA_W-1:0]         operand_2,
  output logic [DATA_W-1:0]         store_data,
  output logic                      load_use_stall,
  output logic [CNT_W-1:0]          stall_cnt
);

  opd1_sel_e           opd1_sel;
  opd2_sel_e           opd2_sel;
  logic                store_op;
  logic                rs_used;
  logic                rt_used;
  logic [DATA_W-1:0]   rs_data;
  logic [DATA_W-1:0]   rt_data;
  logic                rs_pend;
  logic                rt_pend;
  logic                hazard;
  logic                accept;
  logic [ADDR_W-1:0]   link_addr;
  logic [DATA_W-1:0]   op1_next;
  logic [DATA_W-1:0]   op2_next;
  logic [DATA_W-1:0]   sd_next;

  id_operand_pipe_fwd_resolve #(
    .DATA_W(DATA_W), .REG_W(REG_W), .FWD_SRC(FWD_SRC)
  ) u_rs_resolve (
    .reg_addr   (rs_addr),
    .reg_data   (reg_data_1),
    .fwd_valid  (fwd_valid),
    .fwd_pending(fwd_pending),
    .fwd_addr   (fwd_addr),
    .fwd_data   (fwd_data),
    .data       (rs_data),
    .pending    (rs_pend)
  );

  id_operand_pipe_fwd_resolve #(
    .DATA_W(DATA_W), .REG_W(REG_W), .FWD_SRC(FWD_SRC)
  ) u_rt_resolve (
    .reg_addr   (rt_addr),
    .reg_data   (reg_data_2),
    .fwd_valid  (fwd_valid),
    .fwd_pending(fwd_pending),
    .fwd_addr   (fwd_addr),
    .fwd_data   (fwd_data),
    .data       (rt_data),
    .pending    (rt_pend)
  );

  // Operand source decode from opcode/funct.
  always_comb begin
    opd1_sel = OPD1_ZERO;
    opd2_sel = OPD2_ZERO;
    case (op)
      OP_SPECIAL: begin
        if (funct == FN_JALR) opd1_sel = OPD1_LINK;
        else                  opd1_sel = OPD1_REG;
        opd2_sel = OPD2_REG;
      end
      OP_JAL:  opd1_sel = OPD1_LINK;
      OP_BLTZ: opd1_sel = OPD1_REG;
      OP_LUI: begin
        opd1_sel = OPD1_REG;
        opd2_sel = OPD2_HI;
      end
      OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        opd1_sel = OPD1_REG;
        opd2_sel = OPD2_SEXT;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        opd1_sel = OPD1_REG;
        opd2_sel = OPD2_ZEXT;
      end
      default: begin
        if (is_load_op(op) || is_store_op(op)) begin
          opd1_sel = OPD1_REG;
          opd2_sel = OPD2_SEXT;
        end
      end
    endcase
  end

  assign store_op = is_store_op(op);
  assign rs_used  = (opd1_sel == OPD1_REG);
  assign rt_used  = (opd2_sel == OPD2_REG) || store_op;

  // A hazard only counts when the winning bypass for a used register is still pending.
  assign hazard         = (rs_used && rs_pend) || (rt_used && rt_pend);
  assign load_use_stall = in_valid && hazard && !flush;
  assign in_ready       = (!out_valid || out_ready) && !hazard && !flush;
  assign accept         = in_valid && in_ready;

  // Link address wraps at the PC width before being zero-extended to the datapath.
  assign link_addr = addr + ADDR_W'(8);

  // Operand muxes feeding the slot.
  always_comb begin
    op1_next = '0;
    op2_next = '0;
    sd_next  = '0;
    case (opd1_sel)
      OPD1_REG:  op1_next = rs_data;
      OPD1_LINK: op1_next = DATA_W'(link_addr);
      default:   op1_next = '0;
    endcase
    case (opd2_sel)
      OPD2_REG:  op2_next = rt_data;
      OPD2_SEXT: op2_next = DATA_W'($signed(imm));
      OPD2_ZEXT: op2_next = DATA_W'(imm);
      OPD2_HI:   op2_next = DATA_W'({imm, 16'h0000});
      default:   op2_next = '0;
    endcase
    if (store_op) sd_next = rt_data;
  end

  // Pipeline slot: flush beats accept, accept beats drain; operands only move on accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      operand_1  <= '0;
      operand_2  <= '0;
      store_data <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      operand_1  <= op1_next;
      operand_2  <= op2_next;
      store_data <= sd_next;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating load-use stall counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (load_use_stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
